tanso_meter: RTL and testbench

TANSO_METER -- requirements
Module: tanso_meter

---
 rtl/tanso_meter.sv | 126 ++++++++++++
 tb/tb_tanso_meter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/tanso_meter.sv
// Period / high-time meter for a slow asynchronous square wave, with a no-edge timeout.
// Define TANSO_METER_DUTY_EN to build the high-time measurement; otherwise high_time is tied to 0.
module tanso_meter #(
  parameter int unsigned TMO = 20000000,
  parameter int unsigned W   = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         valid,
  output logic         timeout,
  output logic         busy
);

  localparam logic [W-1:0] TMO_W = W'(TMO);
  localparam logic [W-1:0] ONE   = W'(1);

  typedef enum logic {WAIT_RISE, RUN} state_t;

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (v >= TMO_W) ? TMO_W : v + ONE;
  endfunction

  state_t       state_q, state_d;
  logic         sync1_q, s_q, s_dly_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;
  logic [W-1:0] high_q, high_d;
  logic         cap_q, cap_d;
  logic         valid_q;
  logic         timeout_q, timeout_d;
  logic         rise;

  assign rise = s_q & ~s_dly_q;

`ifdef TANSO_METER_DUTY_EN
  logic [W-1:0] hcnt_q, hcnt_d;
  logic [W-1:0] hi_lat_q, hi_lat_d;
  logic         fall;

  assign fall = ~s_q & s_dly_q;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = sat_inc(cnt_q);
    period_d  = period_q;
    high_d    = high_q;
    cap_d     = 1'b0;
    timeout_d = timeout_q;
`ifdef TANSO_METER_DUTY_EN
    hcnt_d    = hcnt_q;
    hi_lat_d  = hi_lat_q;
`endif
    // A rise beats a simultaneous timeout; a rise out of WAIT_RISE only arms the measurement.
    if (rise) begin
      state_d = RUN;
      cnt_d   = ONE;
`ifdef TANSO_METER_DUTY_EN
      hcnt_d  = ONE;
`endif
      if (state_q == RUN) begin
        period_d  = cnt_q;
`ifdef TANSO_METER_DUTY_EN
        high_d    = hi_lat_q;
`endif
        cap_d     = 1'b1;
        timeout_d = 1'b0;
      end
    end else if (cnt_q == TMO_W) begin
      state_d   = WAIT_RISE;
      timeout_d = 1'b1;
      period_d  = '0;
      high_d    = '0;
    end
`ifdef TANSO_METER_DUTY_EN
    else if (state_q == RUN) begin
      if (s_q) hcnt_d = sat_inc(hcnt_q);
      if (fall) hi_lat_d = hcnt_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_RISE;
      sync1_q   <= 1'b0;
      s_q       <= 1'b0;
      s_dly_q   <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      high_q    <= '0;
      cap_q     <= 1'b0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
`ifdef TANSO_METER_DUTY_EN
      hcnt_q    <= '0;
      hi_lat_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      sync1_q   <= sig_in;
      s_q       <= sync1_q;
      s_dly_q   <= s_q;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      cap_q     <= cap_d;
      valid_q   <= cap_q;
      timeout_q <= timeout_d;
`ifdef TANSO_METER_DUTY_EN
      hcnt_q    <= hcnt_d;
      hi_lat_q  <= hi_lat_d;
`endif
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_tanso_meter.sv
// Bench for tanso_meter: square-wave trains (directed and random), timeout, reset and stuck-input cases.
module tb_tanso_meter;
  localparam int TMO = 100;
  localparam int W   = 31;
`ifdef TANSO_METER_DUTY_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic         clk    = 1'b0;
  logic         rst    = 1'b1;
  logic         sig_in = 1'b0;
  logic [W-1:0] period, high_time;
  logic         valid, timeout, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int           c;
    logic [W-1:0] p;
    logic [W-1:0] h;
  } ev_t;
  ev_t obs[$];
  int  tr_p[$];
  int  tr_h[$];

  tanso_meter #(.TMO(TMO), .W(W)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in),
    .period(period), .high_time(high_time),
    .valid(valid), .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (valid === 1'b1) obs.push_back('{cyc, period, high_time});

  initial begin
    #1000000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic do_reset(input logic lvl);
    @(negedge clk); rst = 1'b1; sig_in = lvl;
    @(negedge clk); rst = 1'b0;
    obs.delete();
  endtask

  // Pulse of p cycles, first h high; rc is the cycle the rising level was driven.
  task automatic drive_pulse(input int p, input int h, output int rc);
    rc = 0;
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      sig_in = (i < h);
      if (i == 0) rc = cyc;
    end
  endtask

  task automatic hold(input logic v, input int n);
    repeat (n) begin @(negedge clk); sig_in = v; end
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    checks++; if (period !== '0)     begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
    checks++; if (high_time !== '0)  begin failures++; $display("FAIL reset_high got=%0d exp=0", high_time); end
    checks++; if (valid !== 1'b0)    begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (timeout !== 1'b0)  begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  // Model: every rise after the first of a session yields valid 4 cycles later,
  // reporting the previous pulse's period and high time.
  task automatic test_train(input string nm);
    int           r[$];
    int           rc;
    logic [W-1:0] ep, eh;
    do_reset(1'b0);
    foreach (tr_p[i]) begin
      drive_pulse(tr_p[i], tr_h[i], rc);
      r.push_back(rc);
    end
    hold(1'b0, 8);
    checks++;
    if (obs.size() != r.size() - 1) begin
      failures++; $display("FAIL %s_count got=%0d exp=%0d", nm, obs.size(), r.size() - 1);
    end
    for (int i = 1; i < r.size(); i++) begin
      if (i - 1 >= obs.size()) break;
      ep = W'(tr_p[i-1]);
      eh = DUTY ? W'(tr_h[i-1]) : '0;
      checks++;
      if (obs[i-1].c != r[i] + 4 || obs[i-1].p !== ep || obs[i-1].h !== eh) begin
        failures++;
        $display("FAIL %s_pulse%0d got cyc=%0d p=%0d h=%0d exp cyc=%0d p=%0d h=%0d",
                 nm, i, obs[i-1].c, obs[i-1].p, obs[i-1].h, r[i] + 4, ep, eh);
      end
    end
    checks++;
    if (busy !== 1'b1 || timeout !== 1'b0) begin
      failures++; $display("FAIL %s_status got busy=%b timeout=%b exp busy=1 timeout=0", nm, busy, timeout);
    end
  endtask

  task automatic test_basic;
    tr_p = '{20, 20, 20, 20}; tr_h = '{10, 10, 10, 10};
    test_train("p20h10");
  endtask

  task automatic test_p21;
    tr_p = '{21, 21, 21, 21}; tr_h = '{7, 7, 7, 7};
    test_train("p21h7");
  endtask

  task automatic test_random;
    int p;
    tr_p.delete(); tr_h.delete();
    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(60, 3);
      tr_p.push_back(p);
      tr_h.push_back($urandom_range(p - 1, 1));
    end
    test_train("random");
  endtask

  task automatic test_rise_at_tmo;
    tr_p = '{100, 100, 20}; tr_h = '{50, 30, 10};
    test_train("rise_at_tmo");
  endtask

  task automatic test_timeout_low;
    int rc, r1, ra, rb;
    do_reset(1'b0);
    drive_pulse(20, 10, rc);
    drive_pulse(20, 10, r1);
    for (int i = 0; i < 150; i++) begin
      @(negedge clk); sig_in = 1'b0;
      if (cyc == r1 + 102) begin
        checks++;
        if (timeout !== 1'b0) begin failures++; $display("FAIL tmo_early got=%b exp=0", timeout); end
      end
      if (cyc == r1 + 103) begin
        checks++;
        if (timeout !== 1'b1 || busy !== 1'b0 || period !== '0 || high_time !== '0) begin
          failures++;
          $display("FAIL tmo_hit got timeout=%b busy=%b p=%0d h=%0d exp 1 0 0 0", timeout, busy, period, high_time);
        end
      end
    end
    checks++;
    if (obs.size() != 1 || (obs.size() == 1 && obs[0].p !== W'(20))) begin
      failures++; $display("FAIL tmo_valids got=%0d exp=1", obs.size());
    end
    drive_pulse(20, 10, ra);
    drive_pulse(20, 10, rb);
    hold(1'b0, 8);
    checks++;
    if (obs.size() != 2) begin
      failures++; $display("FAIL tmo_recover_count got=%0d exp=2", obs.size());
    end else if (obs[1].c != rb + 4 || obs[1].p !== W'(20)) begin
      failures++; $display("FAIL tmo_recover got cyc=%0d p=%0d exp cyc=%0d p=20", obs[1].c, obs[1].p, rb + 4);
    end
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL tmo_cleared got=%b exp=0", timeout); end
  endtask

  task automatic test_reset_mid;
    int rc, ra, rb;
    do_reset(1'b0);
    drive_pulse(20, 10, rc);
    drive_pulse(20, 10, rc);
    hold(1'b1, 10);
    hold(1'b0, 5);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    obs.delete();
    checks++;
    if (period !== '0 || high_time !== '0 || valid !== 1'b0 || timeout !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs got p=%0d h=%0d v=%b t=%b b=%b exp all 0", period, high_time, valid, timeout, busy);
    end
    drive_pulse(20, 10, ra);
    drive_pulse(20, 10, rb);
    hold(1'b0, 8);
    checks++;
    if (obs.size() != 1) begin
      failures++; $display("FAIL midrst_count got=%0d exp=1", obs.size());
    end else if (obs[0].c != rb + 4 || obs[0].p !== W'(20)) begin
      failures++; $display("FAIL midrst_pulse got cyc=%0d p=%0d exp cyc=%0d p=20", obs[0].c, obs[0].p, rb + 4);
    end
  endtask

  task automatic test_stuck_high;
    do_reset(1'b1);
    hold(1'b1, 150);
    checks++;
    if (timeout !== 1'b1 || busy !== 1'b0 || period !== '0) begin
      failures++; $display("FAIL stuck_high got timeout=%b busy=%b p=%0d exp 1 0 0", timeout, busy, period);
    end
    checks++;
    if (obs.size() != 0) begin failures++; $display("FAIL stuck_high_valid got=%0d exp=0", obs.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_p21();
    test_random();
    test_rise_at_tmo();
    test_timeout_low();
    test_reset_mid();
    test_stuck_high();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
